// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel push-button debouncer. Each channel has the following stages:
//   - optional pin inversion;
//   - a 2-FF synchroniser;
//   - counter-based stability qualification on a shared sample tick;
//   - registered edge pulses and a long-press pulse.
//
// Parameters:
//   N_CH         number of independent channels (>= 1)
//   SAMPLE_DIV   src_clk cycles per sample tick (>= 1, 1 = tick every cycle)
//   STABLE_TICKS consecutive differing ticks needed to accept a new level
//   LONG_TICKS   ticks the level must stay 1 before long_press fires
//   ACTIVE_LOW   1 = pins are active-low and are inverted before sync
//
// Ports:
//   src_clk        system clock, all state on its rising edge
//   rst_n          asynchronous active-low reset, clears every output
//   en             sample-tick enable, 0 freezes the tick and all qualification
//   pb_in          raw asynchronous button pins
//   level          debounced level, 1 = pressed
//   press          one-cycle pulse on a level 0->1 change
//   release_pulse  one-cycle pulse on a level 1->0 change ("release" is a
//                  reserved word in SystemVerilog, hence the longer name)
//   long_press     one-cycle pulse once a press has been held LONG_TICKS ticks
//   tick           shared sample tick, for observation
// ---------------------------------------------------------------------------
module debounce_multi #(
    parameter int N_CH         = 4,
    parameter int SAMPLE_DIV   = 50000,
    parameter int STABLE_TICKS = 10,
    parameter int LONG_TICKS   = 1000,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic            src_clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_CH-1:0] pb_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic            tick
);

    // Counter widths; a maximum of 0 still needs a 1-bit register.
    localparam int DIV_W  = (SAMPLE_DIV   > 1) ? $clog2(SAMPLE_DIV)   : 1;
    localparam int STAB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int HOLD_W = (LONG_TICKS   > 1) ? $clog2(LONG_TICKS)   : 1;

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS - 1);

    // ------------------------------------------------------------------
    // Shared sample tick
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick_cycle;

    assign tick_cycle = en && (div_cnt == DIV_MAX);
    // With SAMPLE_DIV=1 the counter sits at its maximum during reset, so the
    // observable tick is gated by rst_n to read 0 while reset is asserted.
    assign tick = tick_cycle && rst_n;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values, independent of block ordering.
            div_cnt <= tick_cycle ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Polarity and 2-FF synchroniser
    // ------------------------------------------------------------------
    logic [N_CH-1:0] pin_x;
    logic [N_CH-1:0] sync_1;
    logic [N_CH-1:0] sync_s;

    assign pin_x = ACTIVE_LOW ? ~pb_in : pb_in;

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_s <= '0;
        end else begin
            sync_1 <= pin_x;
            sync_s <= sync_1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel qualification, edge pulses and long press
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [STAB_W-1:0] stab_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic              long_done;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              differs;
        logic              accept;

        assign differs = sync_s[i] != level_q;
        // The new value has persisted for STABLE_TICKS ticks including this one.
        assign accept  = tick_cycle && differs && (stab_cnt == STAB_MAX);

        always_ff @(posedge src_clk or negedge rst_n) begin
            if (!rst_n) begin
                stab_cnt  <= '0;
                hold_cnt  <= '0;
                long_done <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                // Pulses default low, so each is exactly one cycle wide.
                press_q   <= accept && !level_q;
                release_q <= accept && level_q;
                long_q    <= 1'b0;

                if (tick_cycle) begin
                    if (!differs || accept) begin
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_W'(1);
                    end
                    if (accept) begin
                        level_q <= ~level_q;
                    end
                end

                // Hold counting starts on the tick after the press is accepted,
                // saturates at its maximum, and fires once per press on the
                // following tick. A tick that accepts a release never fires.
                if (!level_q) begin
                    hold_cnt  <= '0;
                    long_done <= 1'b0;
                end else if (tick_cycle && !accept) begin
                    if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else if (!long_done) begin
                        long_q    <= 1'b1;
                        long_done <= 1'b1;
                    end
                end
            end
        end

        assign level[i]         = level_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = release_q;
        assign long_press[i]    = long_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi
//
// Two debouncers share the same pins, enable and reset:
//   u_a : SAMPLE_DIV=1, active-high pins
//   u_b : SAMPLE_DIV=5, active-low pins
// Both use N_CH=4, STABLE_TICKS=4 and LONG_TICKS=8.
//
// A cycle-level reference model tracks, per channel:
//   - the run length of disagreeing ticks;
//   - the number of ticks held since the press.
// All DUT outputs are compared against it every cycle. Directed scenarios
// add explicit latency and pulse-count checks.
// ---------------------------------------------------------------------------
module tb_debounce_multi;

    localparam int N_CH   = 4;
    localparam int STABLE = 4;
    localparam int LONG   = 8;
    localparam int DIV_A  = 1;
    localparam int DIV_B  = 5;

    logic            src_clk = 1'b0;
    logic            rst_n   = 1'b1;
    logic            en      = 1'b0;
    logic [N_CH-1:0] pb_in   = '0;

    logic [N_CH-1:0] level_a, press_a, rel_a, long_a;
    logic [N_CH-1:0] level_b, press_b, rel_b, long_b;
    logic            tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    always #5 src_clk = ~src_clk;

    debounce_multi #(
        .N_CH(N_CH), .SAMPLE_DIV(DIV_A), .STABLE_TICKS(STABLE),
        .LONG_TICKS(LONG), .ACTIVE_LOW(1'b0)
    ) u_a (
        .src_clk(src_clk), .rst_n(rst_n), .en(en), .pb_in(pb_in),
        .level(level_a), .press(press_a), .release_pulse(rel_a),
        .long_press(long_a), .tick(tick_a)
    );

    debounce_multi #(
        .N_CH(N_CH), .SAMPLE_DIV(DIV_B), .STABLE_TICKS(STABLE),
        .LONG_TICKS(LONG), .ACTIVE_LOW(1'b1)
    ) u_b (
        .src_clk(src_clk), .rst_n(rst_n), .en(en), .pb_in(pb_in),
        .level(level_b), .press(press_b), .release_pulse(rel_b),
        .long_press(long_b), .tick(tick_b)
    );

    // ---------------- reference model (index 0 = u_a, 1 = u_b) ----------
    int              div_of [2] = '{DIV_A, DIV_B};
    bit              inv_of [2] = '{1'b0, 1'b1};
    int              m_phase [2];
    logic [N_CH-1:0] m_s1 [2];
    logic [N_CH-1:0] m_s2 [2];
    logic [N_CH-1:0] m_level [2];
    logic [N_CH-1:0] m_press [2];
    logic [N_CH-1:0] m_rel [2];
    logic [N_CH-1:0] m_long [2];
    int              m_run [2][N_CH];
    int              m_held [2][N_CH];
    logic            last_tick_b;
    int              bounce [7] = '{1, 1, 1, 0, 1, 1, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_phase[i] = 0;
        m_s1[i]    = '0;
        m_s2[i]    = '0;
        m_level[i] = '0;
        m_press[i] = '0;
        m_rel[i]   = '0;
        m_long[i]  = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_run[i][c]  = 0;
            m_held[i][c] = 0;
        end
    endtask

    function automatic logic model_tick(input int i);
        return rst_n && en && (m_phase[i] == div_of[i] - 1);
    endfunction

    // Advance the model over one rising edge, using pre-edge inputs.
    task automatic model_step(input int i);
        logic            t;
        logic            toggles;
        logic [N_CH-1:0] x;
        if (!rst_n) begin
            model_reset(i);
            return;
        end
        t = model_tick(i);
        x = inv_of[i] ? ~pb_in : pb_in;
        m_press[i] = '0;
        m_rel[i]   = '0;
        m_long[i]  = '0;
        if (t) begin
            for (int c = 0; c < N_CH; c++) begin
                toggles = 1'b0;
                if (m_s2[i][c] != m_level[i][c]) begin
                    m_run[i][c]++;
                    toggles = (m_run[i][c] == STABLE);
                end else begin
                    m_run[i][c] = 0;
                end
                if (m_level[i][c]) begin
                    m_held[i][c]++;
                    if (m_held[i][c] == LONG && !toggles) m_long[i][c] = 1'b1;
                end
                if (toggles) begin
                    m_run[i][c]  = 0;
                    m_held[i][c] = 0;
                    if (m_level[i][c]) m_rel[i][c] = 1'b1;
                    else m_press[i][c] = 1'b1;
                    m_level[i][c] = ~m_level[i][c];
                end
            end
        end
        if (en) m_phase[i] = (m_phase[i] == div_of[i] - 1) ? 0 : m_phase[i] + 1;
        m_s2[i] = m_s1[i];
        m_s1[i] = x;
    endtask

    task automatic compare_all();
        check("a.level", level_a, m_level[0]);
        check("a.press", press_a, m_press[0]);
        check("a.release", rel_a, m_rel[0]);
        check("a.long", long_a, m_long[0]);
        check("a.tick", tick_a, model_tick(0));
        check("b.level", level_b, m_level[1]);
        check("b.press", press_b, m_press[1]);
        check("b.release", rel_b, m_rel[1]);
        check("b.long", long_b, m_long[1]);
        check("b.tick", tick_b, model_tick(1));
        last_tick_b = tick_b;
    endtask

    // One clock cycle. Inputs change on the falling edge, outputs are
    // compared just after, and the model steps just after the rising edge.
    task automatic cycle(input logic [N_CH-1:0] p, input logic e, input logic r);
        @(negedge src_clk);
        pb_in = p;
        en    = e;
        rst_n = r;
        if (!r) begin
            model_reset(0);
            model_reset(1);
        end
        #1;
        compare_all();
        @(posedge src_clk);
        #1;
        model_step(0);
        model_step(1);
    endtask

    // Assert reset between clock edges and confirm outputs clear at once.
    task automatic hit_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst.level_a", level_a, 0);
        check("rst.press_a", press_a, 0);
        check("rst.release_a", rel_a, 0);
        check("rst.long_a", long_a, 0);
        check("rst.tick_a", tick_a, 0);
        check("rst.level_b", level_b, 0);
        check("rst.press_b", press_b, 0);
        check("rst.release_b", rel_b, 0);
        check("rst.long_b", long_b, 0);
        check("rst.tick_b", tick_b, 0);
        model_reset(0);
        model_reset(1);
    endtask

    initial begin
        int lat;
        int cnt;
        int cnt2;
        int n_press;
        int n_long;
        logic [N_CH-1:0] p;
        int len;

        model_reset(0);
        model_reset(1);
        #1 rst_n = 1'b0;
        repeat (3) cycle('0, 1'b1, 1'b0);
        repeat (40) cycle('0, 1'b1, 1'b1);

        // Mid-run asynchronous reset, then recover.
        hit_reset();
        repeat (2) cycle('0, 1'b1, 1'b0);
        repeat (40) cycle('0, 1'b1, 1'b1);

        // Clean press on channel 0 of u_a: level at edge k+5.
        lat = -1;
        cnt = 0;
        for (int n = 0; n < 12; n++) begin
            cycle(4'b0001, 1'b1, 1'b1);
            if (lat < 0 && level_a[0]) lat = n;
            if (press_a[0]) cnt++;
        end
        check("clean.latency", lat, STABLE + 1);
        check("clean.press_count", cnt, 1);
        check("clean.others", level_a[3:1], 3'b000);
        repeat (12) cycle('0, 1'b1, 1'b1);

        // Bounce on channel 1: accepted 5 edges after the final rising capture.
        lat = -1;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            p = '0;
            p[1] = (n < 7) ? bounce[n][0] : 1'b1;
            cycle(p, 1'b1, 1'b1);
            if (lat < 0 && level_a[1]) lat = n;
            if (press_a[1]) cnt++;
        end
        check("bounce.latency", lat, 4 + STABLE + 1);
        check("bounce.press_count", cnt, 1);
        repeat (12) cycle('0, 1'b1, 1'b1);

        // Long press on channel 2, then release.
        n_press = -1;
        n_long  = -1;
        cnt     = 0;
        for (int n = 0; n < 48; n++) begin
            cycle(4'b0100, 1'b1, 1'b1);
            if (press_a[2]) n_press = n;
            if (long_a[2]) begin
                cnt++;
                if (n_long < 0) n_long = n;
            end
        end
        check("long.delay", n_long - n_press, LONG);
        check("long.count", cnt, 1);
        lat = -1;
        for (int n = 0; n < 12; n++) begin
            cycle('0, 1'b1, 1'b1);
            if (lat < 0 && rel_a[2]) lat = n;
        end
        check("release.latency", lat, STABLE + 1);

        // Prescaled tick with en=0 during a held change (u_b releases).
        repeat (40) cycle('0, 1'b1, 1'b1);
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            cycle(4'b1111, 1'b0, 1'b1);
            if (last_tick_b) cnt++;
        end
        check("en.frozen_ticks", cnt, 0);
        check("en.frozen_level", level_b, 4'hF);
        cnt  = 0;
        cnt2 = -1;
        for (int n = 0; n < 60 && cnt2 < 0; n++) begin
            cycle(4'b1111, 1'b1, 1'b1);
            if (last_tick_b) cnt++;
            if (level_b != 4'hF) cnt2 = cnt;
        end
        check("en.ticks_to_accept", cnt2, STABLE);

        // Active-low pins, all four pressed on the same edge.
        repeat (10) cycle(4'b1111, 1'b1, 1'b1);
        cnt = 0;
        for (int n = 0; n < 40 && cnt == 0; n++) begin
            cycle(4'b0000, 1'b1, 1'b1);
            if (press_b != '0) begin
                cnt = 1;
                check("simul.press", press_b, 4'hF);
                check("simul.level", level_b, 4'hF);
            end
        end
        check("simul.seen", cnt, 1);

        // Reset during the hold: no long press, a fresh press afterwards.
        repeat (15) cycle(4'b0000, 1'b1, 1'b1);
        hit_reset();
        repeat (2) cycle(4'b0000, 1'b1, 1'b0);
        cnt  = 0;
        cnt2 = 0;
        for (int n = 0; n < 40; n++) begin
            cycle(4'b0000, 1'b1, 1'b1);
            if (press_b[0]) cnt++;
            if (long_b[0]) cnt2++;
        end
        check("rehold.press_count", cnt, 1);
        check("rehold.long_count", cnt2, 0);

        // Randomised segments: bursts, long holds, en gaps and resets.
        for (int seg = 0; seg < 300; seg++) begin
            p = N_CH'($urandom);
            if ($urandom_range(0, 3) == 0) len = $urandom_range(20, 70);
            else len = $urandom_range(1, 8);
            for (int n = 0; n < len; n++) begin
                cycle(p, ($urandom_range(0, 15) != 0), 1'b1);
            end
            if ($urandom_range(0, 40) == 0) begin
                hit_reset();
                cycle(p, 1'b1, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel push-button debouncer for the GPIO block. It is the successor to the single-channel prescaler/DFF debouncer. Each channel gets:
- a 2-FF synchroniser;
- counter-based stability qualification on a shared sample tick;
- a debounced level output;
- one-cycle press, release and long-press pulses.

It sits between the board pins and the UART/GPIO control logic.

Parameters:
N_CH, 4, number of independent button channels (>=1).
SAMPLE_DIV, 50000, src_clk cycles per sample tick (>=1; 1 = tick every cycle, test mode).
STABLE_TICKS, 10, consecutive ticks a new value must persist before the level changes (>=1).
LONG_TICKS, 1000, ticks the level must stay 1 before long_press fires (>=1).
ACTIVE_LOW, 0, 1 = pins are active-low and are inverted before synchronisation.

Ports:
src_clk  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  sample-tick enable; 0 freezes tick generation.
pb_in  input  N_CH  raw button pins (asynchronous).
level  output  N_CH  debounced level, 1 = pressed.
press  output  N_CH  one-cycle pulse on a level 0->1 transition.
release  output  N_CH  one-cycle pulse on a level 1->0 transition.
long_press  output  N_CH  one-cycle pulse when a press has been held for LONG_TICKS ticks.
tick  output  1  shared sample tick (for observation/testing).

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following clear immediately; every output reads 0.
  - level, press, release, long_press, tick = 0;
  - synchroniser FFs = 0 (post-polarity inactive);
  - tick counter, stability counters and hold counters = 0.
- Polarity: x = ACTIVE_LOW ? ~pb_in : pb_in. x passes through a 2-FF synchroniser per channel to give s[i].
- Tick generator:
  - Counter runs 0..SAMPLE_DIV-1 while en=1; tick=1 for the one cycle in which counter==SAMPLE_DIV-1, then the counter wraps to 0.
  - en=0: counter holds its value, tick=0. No stability or hold counter advances, and level holds.
  - Widths: $clog2 of each maximum. Counters never exceed their maximum.
- Per-channel stability (evaluated only on tick cycles):
  - s[i]==level[i]: stab_cnt cleared to 0.
  - s[i]!=level[i] and stab_cnt==STABLE_TICKS-1: level toggles and stab_cnt clears.
  - s[i]!=level[i] otherwise: stab_cnt increments.
  - Result: a change is accepted only after STABLE_TICKS consecutive differing ticks. Any agreeing tick restarts qualification.
- Latency, for SAMPLE_DIV=1: if edge k is the first edge at which sync stage 1 captures the new value, level updates at edge k+1+STABLE_TICKS.
- Edge pulses:
  - press[i] and release[i] are registered on the same edge as the level update, so they are high in the first cycle level shows its new value.
  - Each is exactly 1 cycle wide.
- Long press:
  - hold_cnt increments on each tick while level[i]=1; it clears whenever level[i]=0.
  - When hold_cnt reaches LONG_TICKS-1 on a tick, long_press pulses 1 cycle and hold_cnt saturates; there is no repeat until release.
  - The hold count starts on the tick after the press is accepted.
  - Release before threshold: no long_press.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-qualification or mid-hold discards all progress. After rst_n deasserts, a button already held needs the full sync + STABLE_TICKS again and produces a fresh press pulse.
- Glitch shorter than STABLE_TICKS ticks: no level change and no pulse.

Test Plan:
1. Reset: N_CH=4, SAMPLE_DIV=1, STABLE_TICKS=4; assert rst_n=0 mid-run -> all outputs 0 immediately, with no clock edge needed.
2. Clean press: same parameters; pb_in[0] 0->1 captured at edge k and held -> level[0]=1 and press[0]=1 at edge k+5. press[0]=0 at k+6. Other channels stay 0.
3. Bounce: pb_in[1] toggles high 3 cycles, low 1, high 3, then stays high -> no level change during bouncing. level[1]=1 exactly 5 edges after the final rising capture, with a single press pulse.
4. Release and long press: LONG_TICKS=8; hold pb_in[2] high -> long_press[2] pulses once, 8 ticks after press[2]. Holding 20 further cycles -> no repeat. Drop the input -> release[2] pulses 5 edges after capture.
5. Prescaled tick/en: SAMPLE_DIV=5 -> tick high 1 of every 5 cycles. With en=0 for 30 cycles during a held change -> tick=0 and level unchanged. After en=1, the press is accepted after STABLE_TICKS more ticks.
6. Polarity/simultaneity: ACTIVE_LOW=1; pins idle 1, then all four driven 0 on the same edge -> level=4'b1111 and press=4'b1111 on the same cycle. Reset during a hold -> no long_press, and a fresh press follows deassertion.
